// File: rtl/fpu_div_pkg.sv
// Shared types and constants for the sequential single-precision divider.
package fpu_div_pkg;

   // Field widths of the binary32 format this package describes
   localparam int unsigned EXP_BITS  = 8;
   localparam int unsigned FRAC_BITS = 23;

   localparam int unsigned BIAS     = 127;
   localparam int unsigned EXP_MAX  = 255;
   localparam logic [31:0] QNAN     = 32'h7FC0_0000;
   // One quotient bit per cycle: hidden bit, 23 fraction bits, guard, one extra
   localparam int unsigned DIV_ITER = 26;

   typedef enum logic [1:0] {
      StIdle,
      StDivide,
      StNorm,
      StDone
   } state_e;

   typedef enum logic [1:0] {
      ClsZero,
      ClsNormal,
      ClsInf,
      ClsNan
   } op_class_e;

   // Subnormals are flushed, so any zero exponent counts as zero
   function automatic op_class_e classify(input logic [EXP_BITS-1:0]  exp,
                                          input logic [FRAC_BITS-1:0] frac);
      op_class_e cls;
      if (exp == '0) begin
         cls = ClsZero;
      end else if (exp == '1) begin
         cls = (frac == '0) ? ClsInf : ClsNan;
      end else begin
         cls = ClsNormal;
      end
      return cls;
   endfunction

endpackage

// File: rtl/subtractor_8b.sv
// Biased exponent difference for division: exp1 - exp2 + bias, as a signed value
// wide enough to hold every combination, plus early out-of-range indications.
module subtractor_8b #(
   parameter int unsigned EXP_W = 8,
   parameter int          BIAS  = 127
) (
   input  logic        [EXP_W-1:0] exp1_i,
   input  logic        [EXP_W-1:0] exp2_i,
   output logic signed [EXP_W+1:0] diff_o,
   // Still overflowing even if normalization later subtracts one
   output logic                    ovf_o,
   // Still underflowing even if rounding later adds one
   output logic                    unf_o
);
   import fpu_div_pkg::*;

   localparam int unsigned EW = EXP_W + 2;
   localparam logic signed [EW-1:0] BiasS     = EW'(BIAS);
   localparam logic signed [EW-1:0] ExpOvfLim = EW'(2 ** EXP_W);

   // Difference and range indications
   always_comb begin
      diff_o = $signed({2'b00, exp1_i}) - $signed({2'b00, exp2_i}) + BiasS;
      ovf_o  = diff_o >= ExpOvfLim;
      unf_o  = diff_o[EW-1];
   end

endmodule

// File: rtl/divider_32b.sv
// Sequential IEEE-754 single-precision divider. Restoring division produces one
// quotient bit per cycle, followed by a single normalize/round cycle. Special
// operands bypass the iteration and finish in the accept cycle. Subnormal inputs
// are treated as zero and subnormal results are flushed to zero.
module divider_32b #(
   parameter int unsigned EXP_W  = 8,
   parameter int unsigned FRAC_W = 23,
   parameter int          BIAS   = 127
) (
   input  logic                    CLK,
   input  logic                    nRST,
   input  logic                    start,
   input  logic [EXP_W+FRAC_W:0]   floating_point1,
   input  logic [EXP_W+FRAC_W:0]   floating_point2,
   output logic [EXP_W+FRAC_W:0]   result,
   output logic                    busy,
   output logic                    done,
   output logic                    ovf,
   output logic                    unf,
   output logic                    dz,
   output logic                    nv
);
   import fpu_div_pkg::*;

   localparam int unsigned W    = 1 + EXP_W + FRAC_W;
   localparam int unsigned SigW = FRAC_W + 1;
   localparam int unsigned RemW = FRAC_W + 2;
   localparam int unsigned QW   = FRAC_W + 3;
   localparam int unsigned EW   = EXP_W + 2;
   localparam int unsigned CntW = $clog2(QW);
   localparam logic signed [EW-1:0] ExpMaxS = EW'(2 ** EXP_W - 1);

   // State
   state_e            state_q;
   logic [EXP_W-1:0]  exp1_q, exp2_q;
   logic              sign_q;
   logic [RemW-1:0]   rem_q;
   logic [SigW-1:0]   div_q;
   logic [QW-1:0]     q_q;
   logic [CntW-1:0]   cnt_q;
   logic [W-1:0]      result_q;
   logic              busy_q, done_q, ovf_q, unf_q, dz_q, nv_q;

   // Operand decode
   op_class_e         cls1, cls2;
   logic              sign_x;
   logic              spec_hit, spec_nv, spec_dz;
   logic [W-1:0]      spec_res;
   logic [W-1:0]      qnan_w, inf_x, zero_x;

   // Iteration
   logic              rem_ge;
   logic [RemW-1:0]   rem_sub, rem_d;
   logic [QW-1:0]     q_d;

   // Normalize / round
   logic signed [EW-1:0] exp_diff, exp_fin;
   logic              sub_ovf, sub_unf;
   logic              norm_shift, guard, sticky, round_up, round_carry;
   logic [SigW-1:0]   sig_pre, sig_rnd;
   logic              norm_ovf, norm_unf;
   logic [W-1:0]      norm_res;

   assign result = result_q;
   assign busy   = busy_q;
   assign done   = done_q;
   assign ovf    = ovf_q;
   assign unf    = unf_q;
   assign dz     = dz_q;
   assign nv     = nv_q;

   assign cls1   = classify(floating_point1[W-2 -: EXP_W], floating_point1[FRAC_W-1:0]);
   assign cls2   = classify(floating_point2[W-2 -: EXP_W], floating_point2[FRAC_W-1:0]);
   assign sign_x = floating_point1[W-1] ^ floating_point2[W-1];
   assign qnan_w = {1'b0, {EXP_W{1'b1}}, 1'b1, {(FRAC_W-1){1'b0}}};
   assign inf_x  = {sign_x, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
   assign zero_x = {sign_x, {(W-1){1'b0}}};

   // Special-operand results that skip the iteration entirely
   always_comb begin
      spec_hit = 1'b1;
      spec_nv  = 1'b0;
      spec_dz  = 1'b0;
      spec_res = '0;
      if (cls1 == ClsNan || cls2 == ClsNan) begin
         spec_res = qnan_w;
         // Quiet bit clear marks a signalling NaN
         spec_nv  = (cls1 == ClsNan && !floating_point1[FRAC_W-1]) ||
                    (cls2 == ClsNan && !floating_point2[FRAC_W-1]);
      end else if ((cls1 == ClsZero && cls2 == ClsZero) ||
                   (cls1 == ClsInf  && cls2 == ClsInf)) begin
         spec_res = qnan_w;
         spec_nv  = 1'b1;
      end else if (cls1 == ClsInf) begin
         spec_res = inf_x;
      end else if (cls2 == ClsZero) begin
         spec_res = inf_x;
         spec_dz  = 1'b1;
      end else if (cls1 == ClsZero || cls2 == ClsInf) begin
         spec_res = zero_x;
      end else begin
         spec_hit = 1'b0;
      end
   end

   // One restoring-division step; remainder never exceeds twice the divisor
   always_comb begin
      rem_ge  = rem_q >= {1'b0, div_q};
      rem_sub = rem_ge ? (rem_q - {1'b0, div_q}) : rem_q;
      rem_d   = {rem_sub[RemW-2:0], 1'b0};
      q_d     = {q_q[QW-2:0], rem_ge};
   end

   subtractor_8b #(
      .EXP_W (EXP_W),
      .BIAS  (BIAS)
   ) u_exp_sub (
      .exp1_i (exp1_q),
      .exp2_i (exp2_q),
      .diff_o (exp_diff),
      .ovf_o  (sub_ovf),
      .unf_o  (sub_unf)
   );

   // Normalize the quotient, round to nearest even, range-check the exponent
   always_comb begin
      norm_shift = ~q_q[QW-1];
      if (q_q[QW-1]) begin
         sig_pre = q_q[QW-1:2];
         guard   = q_q[1];
         sticky  = q_q[0] | (|rem_q);
      end else begin
         sig_pre = q_q[QW-2:1];
         guard   = q_q[0];
         sticky  = |rem_q;
      end
      round_up = guard & (sticky | sig_pre[0]);
      // On carry-out the low bits are already zero, i.e. significand 1.0
      {round_carry, sig_rnd} = {1'b0, sig_pre} + {{SigW{1'b0}}, round_up};
      exp_fin  = exp_diff - $signed(EW'(norm_shift)) + $signed(EW'(round_carry));
      norm_ovf = sub_ovf | (exp_fin >= ExpMaxS);
      norm_unf = ~norm_ovf & (sub_unf | exp_fin[EW-1] | (exp_fin == '0));
      if (norm_ovf) begin
         norm_res = {sign_q, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
      end else if (norm_unf) begin
         norm_res = {sign_q, {(W-1){1'b0}}};
      end else begin
         norm_res = {sign_q, exp_fin[EXP_W-1:0], sig_rnd[FRAC_W-1:0]};
      end
   end

   // Control FSM with registered outputs
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         state_q  <= StIdle;
         exp1_q   <= '0;
         exp2_q   <= '0;
         sign_q   <= 1'b0;
         rem_q    <= '0;
         div_q    <= '0;
         q_q      <= '0;
         cnt_q    <= '0;
         result_q <= '0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         ovf_q    <= 1'b0;
         unf_q    <= 1'b0;
         dz_q     <= 1'b0;
         nv_q     <= 1'b0;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (start) begin
                  busy_q <= 1'b1;
                  ovf_q  <= 1'b0;
                  unf_q  <= 1'b0;
                  exp1_q <= floating_point1[W-2 -: EXP_W];
                  exp2_q <= floating_point2[W-2 -: EXP_W];
                  sign_q <= sign_x;
                  if (spec_hit) begin
                     result_q <= spec_res;
                     dz_q     <= spec_dz;
                     nv_q     <= spec_nv;
                     done_q   <= 1'b1;
                     state_q  <= StDone;
                  end else begin
                     dz_q    <= 1'b0;
                     nv_q    <= 1'b0;
                     rem_q   <= {2'b01, floating_point1[FRAC_W-1:0]};
                     div_q   <= {1'b1, floating_point2[FRAC_W-1:0]};
                     q_q     <= '0;
                     cnt_q   <= CntW'(QW - 1);
                     state_q <= StDivide;
                  end
               end
            end
            StDivide: begin
               rem_q <= rem_d;
               q_q   <= q_d;
               cnt_q <= cnt_q - 1'b1;
               if (cnt_q == '0) begin
                  state_q <= StNorm;
               end
            end
            StNorm: begin
               result_q <= norm_res;
               ovf_q    <= norm_ovf;
               unf_q    <= norm_unf;
               done_q   <= 1'b1;
               state_q  <= StDone;
            end
            StDone: begin
               done_q  <= 1'b0;
               busy_q  <= 1'b0;
               state_q <= StIdle;
            end
            default: state_q <= StIdle;
         endcase
      end
   end

endmodule
